mult_share_arbiter: RTL and testbench

//  Shares one combinational 32x32 unsigned multiplier (module multiplier: in1, in2 -> out[63:0])

---
 rtl/mult_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one combinational WIDTHxWIDTH
// unsigned multiplier between NUM_REQ requesters, valid/ready on both sides.
// Operands and product are registered, so one op takes IDLE -> MUL -> RESP.
// Optional feature macro: MULT_OP_COUNT_EN adds a saturating 16-bit op_count
// output that counts completed responses.

// Combinational full-width unsigned multiplier owned by the arbiter.
module multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic [2*WIDTH-1:0] out
);
    localparam int unsigned PW = 2 * WIDTH;

    // Operands are widened first so the product is never truncated.
    assign out = PW'(in1) * PW'(in2);
endmodule

module mult_share_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    parameter  int unsigned WIDTH   = 32,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_out
`ifdef MULT_OP_COUNT_EN
    ,
    output logic [15:0]              op_count
`endif
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_id;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic [2*WIDTH-1:0]   w_product;
    logic                 w_grant_vld;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_req_fire;
    logic                 w_resp_fire;

    // (base + off) mod NUM_REQ, valid for off < NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    multiplier #(.WIDTH(WIDTH)) u_mult (
        .in1 (r_op_a),
        .in2 (r_op_b),
        .out (w_product)
    );

    // Round-robin search for the first valid requester starting at r_rr_ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_vld && req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = wrap_add(r_rr_ptr, k);
            end
        end
    end

    // Grant is offered only while idle; one-hot or zero.
    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_grant_vld) begin
            req_ready = NUM_REQ'(1) << w_grant_idx;
        end
    end

    assign w_req_fire  = |(req_valid & req_ready);
    assign w_resp_fire = (r_state == S_RESP) && resp_valid && resp_ready;

    // Arbitration FSM: latch winner's operands, register product, hold until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_op_a  <= req_in1[32'(w_grant_idx)*WIDTH +: WIDTH];
                        r_op_b  <= req_in2[32'(w_grant_idx)*WIDTH +: WIDTH];
                        r_id    <= w_grant_idx;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    resp_out   <= w_product;
                    resp_id    <= r_id;
                    resp_valid <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_fire) begin
                        resp_valid <= 1'b0;
                        r_rr_ptr   <= wrap_add(r_id, 1);
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MULT_OP_COUNT_EN
    // Saturating count of completed responses; sticks at 0xFFFF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (w_resp_fire && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`else
    // Build without the completion counter: no extra port or state.
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (NUM_REQ=2, WIDTH=32).
// Define MULT_OP_COUNT_EN to also check the completion counter.
`timescale 1ns/1ps
module tb_mult_share_arbiter;
    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_in1;
    logic [63:0] req_in2;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [63:0] resp_out;
`ifdef MULT_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    int n_total = 0;
    int n_bad   = 0;

    mult_share_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out   (resp_out)
`ifdef MULT_OP_COUNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single checker: counts every comparison, reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full op with resp_ready=1 and inputs already driven:
    // grant in IDLE, MUL cycle, RESP cycle with product, back to IDLE.
    task automatic run_op(input int exp_id, input logic [63:0] exp_prod);
        logic [1:0] oh;
        oh = 2'b01 << exp_id;
        #1;
        chk("grant", 64'(req_ready), 64'(oh));
        step();
        chk("mul_no_valid", 64'(resp_valid), 64'd0);
        chk("mul_no_ready", 64'(req_ready), 64'd0);
        step();
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("resp_id", 64'(resp_id), 64'(exp_id));
        chk("resp_out", resp_out, exp_prod);
        step();
        chk("idle_no_valid", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_in1    = '0;
        req_in2    = '0;
        resp_ready = 1'b1;
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_out", resp_out, 64'd0);
        rst_n = 1'b1;
        step();

        // Single op from requester 0: 3*5.
        req_in1   = {32'd0, 32'd3};
        req_in2   = {32'd0, 32'd5};
        req_valid = 2'b01;
        run_op(0, 64'd15);

        // Operand extremes.
        req_in1 = {32'd0, 32'hFFFF_FFFF};
        req_in2 = {32'd0, 32'hFFFF_FFFF};
        run_op(0, 64'hFFFF_FFFE_0000_0001);
        req_in1 = {32'd0, 32'd0};
        req_in2 = {32'd0, 32'hDEAD_BEEF};
        run_op(0, 64'd0);

        // Requester 1 alone; junk on requester 0's slice is ignored.
        req_valid = 2'b10;
        req_in1   = {32'h1234_5678, 32'hDEAD_BEEF};
        req_in2   = {32'h0000_0010, 32'hFFFF_FFFF};
        run_op(1, 64'h1_2345_6780);

        // Contention: both valid, alternating grants from rr_ptr=0.
        req_valid = 2'b11;
        req_in1   = {32'h0001_0000, 32'd7};
        req_in2   = {32'h0001_0000, 32'd9};
        run_op(0, 64'd63);
        run_op(1, 64'h1_0000_0000);
        run_op(0, 64'd63);
        run_op(1, 64'h1_0000_0000);

        // Backpressure: RESP held for 10 cycles with everything stable.
        resp_ready = 1'b0;
        req_in1    = {32'd2, 32'd6};
        req_in2    = {32'd100, 32'd7};
        #1;
        chk("bp_grant", 64'(req_ready), 64'd1);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_out", resp_out, 64'd42);
            chk("bp_id", 64'(resp_id), 64'd0);
            chk("bp_no_ready", 64'(req_ready), 64'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_valid", 64'(resp_valid), 64'd1);
        step();
        chk("bp_done_valid", 64'(resp_valid), 64'd0);
        chk("bp_next_grant", 64'(req_ready), 64'd2);
        req_valid = 2'b00;

        // Reset during MUL discards the op and clears rr_ptr.
        req_valid = 2'b10;
        #1;
        chk("rm_grant", 64'(req_ready), 64'd2);
        step();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        step();
        chk("rm_resp_valid", 64'(resp_valid), 64'd0);
        chk("rm_resp_out", resp_out, 64'd0);
        chk("rm_resp_id", 64'(resp_id), 64'd0);
        chk("rm_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("rm_no_resp", 64'(resp_valid), 64'd0);

        // Both valid after reset: grant restarts at 0; five completions.
        req_valid = 2'b11;
        run_op(0, 64'd42);
        run_op(1, 64'd200);
        run_op(0, 64'd42);
        run_op(1, 64'd200);
        run_op(0, 64'd42);
        req_valid = 2'b00;
`ifdef MULT_OP_COUNT_EN
        chk("op_count", 64'(op_count), 64'd5);
`endif
        step();
        chk("end_idle", 64'(resp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
